// File: rtl/lab_pkg.sv
// Shared definitions for the lab's stream blocks: route select encodings and
// a constant-function log2 used to size FIFO pointers.
package lab_pkg;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    // Ceiling log2 for elaboration-time sizing; returns 0 for values <= 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/lab_fifo.sv
// Small synchronous FIFO with one extra pointer bit so that full and empty
// can be told apart from the pointer MSBs alone.
module lab_fifo
    import lab_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]    wrPtr_q, wrPtr_d;
    logic [PW-1:0]    rdPtr_q, rdPtr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             doPush, doPop;

    assign empty = (wrPtr_q == rdPtr_q);
    assign full  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);

    assign doPush = push && !full;
    assign doPop  = pop && !empty;

    // Forcing the head to zero when empty keeps the output clean after reset.
    assign pop_data = empty ? '0 : mem_q[rdPtr_q[AW-1:0]];

    always_comb begin
        wrPtr_d = wrPtr_q + PW'(doPush);
        rdPtr_d = rdPtr_q + PW'(doPop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/lab_demux_router.sv
// Registered 1:2 stream demultiplexer: each accepted beat is queued in the
// FIFO of the output chosen by in_sel; per-output counters track pops.
module lab_demux_router
    import lab_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [WIDTH-1:0] b_data,
    output logic [CNT_W-1:0] a_count,
    output logic [CNT_W-1:0] b_count
);

    logic             aFull, aEmpty, bFull, bEmpty;
    logic             pushA, pushB, popA, popB;
    logic [CNT_W-1:0] aCount_q, aCount_d;
    logic [CNT_W-1:0] bCount_q, bCount_d;

    // Ready looks only at the selected FIFO's registered full flag, never at
    // the consumer readies, so a same-cycle pop cannot make room.
    assign in_ready = (in_sel == SEL_B) ? !bFull : !aFull;

    assign pushA = in_valid && in_ready && (in_sel == SEL_A);
    assign pushB = in_valid && in_ready && (in_sel == SEL_B);

    assign a_valid = !aEmpty;
    assign b_valid = !bEmpty;
    assign popA    = a_valid && a_ready;
    assign popB    = b_valid && b_ready;

    lab_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) fifoA (
        .clk      (clk),
        .reset    (reset),
        .push     (pushA),
        .push_data(in_data),
        .pop      (popA),
        .pop_data (a_data),
        .full     (aFull),
        .empty    (aEmpty)
    );

    lab_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) fifoB (
        .clk      (clk),
        .reset    (reset),
        .push     (pushB),
        .push_data(in_data),
        .pop      (popB),
        .pop_data (b_data),
        .full     (bFull),
        .empty    (bEmpty)
    );

    always_comb begin
        aCount_d = aCount_q + CNT_W'(popA);
        bCount_d = bCount_q + CNT_W'(popB);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            aCount_q <= '0;
            bCount_q <= '0;
        end else begin
            aCount_q <= aCount_d;
            bCount_q <= bCount_d;
        end
    end

    assign a_count = aCount_q;
    assign b_count = bCount_q;

endmodule

// File: tb/tb_lab_demux_router.sv
// Bench for lab_demux_router: a directed vector table plus a queue-based
// reference model that predicts ready, valids, head data and counts each cycle.
module tb_lab_demux_router;

    localparam int WIDTH = 8;
    localparam int DEPTH = 2;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             a_valid, a_ready;
    logic [WIDTH-1:0] a_data;
    logic             b_valid, b_ready;
    logic [WIDTH-1:0] b_data;
    logic [CNT_W-1:0] a_count, b_count;

    int compared   = 0;
    int mismatched = 0;

    logic [WIDTH-1:0] qA[$];
    logic [WIDTH-1:0] qB[$];
    logic [CNT_W-1:0] cntA, cntB;

    typedef struct {
        logic             v;
        logic             sel;
        logic [WIDTH-1:0] data;
        logic             ar;
        logic             br;
        logic             expIr;
        logic             expAv;
        logic [WIDTH-1:0] expAd;
        logic             expBv;
        logic [WIDTH-1:0] expBd;
        logic [CNT_W-1:0] expAc;
        logic [CNT_W-1:0] expBc;
    } vec_t;

    vec_t tbl[6];

    always #5 clk = ~clk;

    lab_demux_router #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data (in_data),
        .in_sel  (in_sel),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .a_data  (a_data),
        .b_valid (b_valid),
        .b_ready (b_ready),
        .b_data  (b_data),
        .a_count (a_count),
        .b_count (b_count)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared = compared + 1;
        if (act !== exp) begin
            mismatched = mismatched + 1;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called one time unit after a rising edge; leaves outputs settled well
    // before the next edge.
    task automatic applyStimulus(input logic v, input logic sel, input logic [WIDTH-1:0] data,
                                 input logic ar, input logic br);
        in_valid = v;
        in_sel   = sel;
        in_data  = data;
        a_ready  = ar;
        b_ready  = br;
        #3;
    endtask

    // Compare against the reference queues, then commit this cycle's
    // accept/pop to the model and advance past the clock edge.
    task automatic scoreboardStep();
        logic expIr, popA, popB;
        expIr = in_sel ? (qB.size() < DEPTH) : (qA.size() < DEPTH);
        checkOutput("sb_in_ready", in_ready, expIr);
        checkOutput("sb_a_valid", a_valid, qA.size() != 0);
        checkOutput("sb_b_valid", b_valid, qB.size() != 0);
        if (qA.size() != 0) checkOutput("sb_a_data", a_data, qA[0]);
        if (qB.size() != 0) checkOutput("sb_b_data", b_data, qB[0]);
        checkOutput("sb_a_count", a_count, cntA);
        checkOutput("sb_b_count", b_count, cntB);
        popA = (qA.size() != 0) && a_ready;
        popB = (qB.size() != 0) && b_ready;
        if (popA) begin
            void'(qA.pop_front());
            cntA = cntA + 1'b1;
        end
        if (popB) begin
            void'(qB.pop_front());
            cntB = cntB + 1'b1;
        end
        if (in_valid && expIr) begin
            if (in_sel) qB.push_back(in_data);
            else        qA.push_back(in_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic v, input logic sel, input logic [WIDTH-1:0] data,
                        input logic ar, input logic br);
        applyStimulus(v, sel, data, ar, br);
        scoreboardStep();
    endtask

    task automatic doReset();
        reset    = 1'b1;
        in_valid = 1'b1;
        in_sel   = 1'b0;
        in_data  = 8'hEE;
        a_ready  = 1'b1;
        b_ready  = 1'b1;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        qA.delete();
        qB.delete();
        cntA = '0;
        cntB = '0;
    endtask

    initial begin
        // v sel data ar br | in_ready a_valid a_data b_valid b_data a_cnt b_cnt
        tbl[0] = '{1'b1, 1'b0, 8'h11, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'd0, 8'd0};
        tbl[1] = '{1'b1, 1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 8'h00, 8'd0, 8'd0};
        tbl[2] = '{1'b1, 1'b0, 8'h33, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h22, 8'd1, 8'd0};
        tbl[3] = '{1'b1, 1'b1, 8'h44, 1'b1, 1'b1, 1'b1, 1'b1, 8'h33, 1'b0, 8'h00, 8'd1, 8'd1};
        tbl[4] = '{1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h44, 8'd2, 8'd1};
        tbl[5] = '{1'b0, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'd2, 8'd2};

        reset    = 1'b1;
        in_valid = 1'b0;
        in_sel   = 1'b0;
        in_data  = '0;
        a_ready  = 1'b0;
        b_ready  = 1'b0;
        doReset();

        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("rst_in_ready", in_ready, 1'b1);
        checkOutput("rst_a_valid", a_valid, 1'b0);
        checkOutput("rst_b_valid", b_valid, 1'b0);
        checkOutput("rst_a_data", a_data, 8'h00);
        checkOutput("rst_b_data", b_data, 8'h00);
        scoreboardStep();

        // Alternating A/B traffic with both consumers ready.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(tbl[i].v, tbl[i].sel, tbl[i].data, tbl[i].ar, tbl[i].br);
            checkOutput($sformatf("vec%0d_in_ready", i), in_ready, tbl[i].expIr);
            checkOutput($sformatf("vec%0d_a_valid", i), a_valid, tbl[i].expAv);
            checkOutput($sformatf("vec%0d_b_valid", i), b_valid, tbl[i].expBv);
            if (tbl[i].expAv) checkOutput($sformatf("vec%0d_a_data", i), a_data, tbl[i].expAd);
            if (tbl[i].expBv) checkOutput($sformatf("vec%0d_b_data", i), b_data, tbl[i].expBd);
            checkOutput($sformatf("vec%0d_a_count", i), a_count, tbl[i].expAc);
            checkOutput($sformatf("vec%0d_b_count", i), b_count, tbl[i].expBc);
            scoreboardStep();
        end

        // Stall A until full; B must keep flowing.
        step(1'b1, 1'b0, 8'hA0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 8'hA1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 8'hA2, 1'b0, 1'b1);
        checkOutput("a_full_in_ready", in_ready, 1'b0);
        scoreboardStep();
        applyStimulus(1'b1, 1'b1, 8'hB0, 1'b0, 1'b1);
        checkOutput("b_while_a_full_in_ready", in_ready, 1'b1);
        scoreboardStep();
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("b_while_a_full_b_valid", b_valid, 1'b1);
        checkOutput("b_while_a_full_b_data", b_data, 8'hB0);
        scoreboardStep();

        // Full A with consumer ready: no pass-through this cycle.
        applyStimulus(1'b1, 1'b0, 8'hA2, 1'b1, 1'b1);
        checkOutput("no_passthru_in_ready", in_ready, 1'b0);
        scoreboardStep();
        applyStimulus(1'b1, 1'b0, 8'hA2, 1'b1, 1'b1);
        checkOutput("after_pop_in_ready", in_ready, 1'b1);
        scoreboardStep();
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

        // Push into empty A with ready high: no bypass.
        applyStimulus(1'b1, 1'b0, 8'h55, 1'b1, 1'b1);
        checkOutput("no_bypass_a_valid", a_valid, 1'b0);
        scoreboardStep();
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        checkOutput("bypass_next_a_valid", a_valid, 1'b1);
        checkOutput("bypass_next_a_data", a_data, 8'h55);
        scoreboardStep();

        // 256 beats through B: counter wraps back to zero.
        doReset();
        for (int i = 0; i < 256; i++) begin
            step(1'b1, 1'b1, 8'(i), 1'b1, 1'b1);
        end
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        checkOutput("b_count_255", b_count, 8'd255);
        scoreboardStep();
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        checkOutput("b_count_wrap", b_count, 8'd0);
        scoreboardStep();

        // Reset with both FIFOs holding a beat and a beat in flight.
        step(1'b1, 1'b0, 8'h61, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h62, 1'b0, 1'b0);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_sel   = 1'b0;
        in_data  = 8'h63;
        @(posedge clk);
        #1;
        reset = 1'b0;
        qA.delete();
        qB.delete();
        cntA = '0;
        cntB = '0;
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("midrst_a_valid", a_valid, 1'b0);
        checkOutput("midrst_b_valid", b_valid, 1'b0);
        checkOutput("midrst_a_data", a_data, 8'h00);
        checkOutput("midrst_b_data", b_data, 8'h00);
        checkOutput("midrst_a_count", a_count, 8'd0);
        checkOutput("midrst_b_count", b_count, 8'd0);
        checkOutput("midrst_in_ready_a", in_ready, 1'b1);
        scoreboardStep();
        applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        checkOutput("midrst_in_ready_b", in_ready, 1'b1);
        scoreboardStep();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/lab_demux_router.md
# lab_demux_router

Registered 1:2 demultiplexer: the inverse of the lab's 2:1 select mux (`z = c ? b : a`). Each input beat on a valid/ready stream is steered by `in_sel` to output A (`sel=0`) or output B (`sel=1`). Each output has its own small FIFO, so a stalled consumer on one side never blocks the other side once its beats are queued. Per-output beat counters feed the lab's pass/fail self-check harness.

## Interface
- `WIDTH`, 8: data width of input and both outputs.
- `DEPTH`, 2: entries per output FIFO; power of two, ≥2.
- `CNT_W`, 8: width of per-output beat counters.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: input beat present.
- `in_ready` out 1: input beat accepted this cycle when `in_valid & in_ready`.
- `in_data` in WIDTH: input payload.
- `in_sel` in 1: route select; 0 → A, 1 → B; sampled together with `in_data`.
- `a_valid` out 1, `a_ready` in 1, `a_data` out WIDTH: output A stream.
- `b_valid` out 1, `b_ready` in 1, `b_data` out WIDTH: output B stream.
- `a_count` out CNT_W, `b_count` out CNT_W: beats delivered on A / B (popped, not pushed).

## Operation
- Accept: `in_ready = in_sel ? !b_full : !a_full`. The value is combinational from `in_sel` and registered FIFO state only; it never depends on `a_ready` or `b_ready`.
- On accept, `{in_data}` is pushed into the FIFO selected by `in_sel`. The other FIFO is untouched.
- Full FIFO: `in_ready` is low for that select even if the same-cycle pop frees an entry. No full-pass-through.
- Output: `x_valid = !x_empty`, and `x_data` = FIFO head. Pop when `x_valid & x_ready`.
- Simultaneous push and pop on the same non-full, non-empty FIFO: occupancy is unchanged, order is preserved.
- Push into an empty FIFO with `x_ready` high in the same cycle: no bypass. The beat appears the next cycle.
- Counters: `x_count` increments by 1 on each pop and wraps from 2^CNT_W−1 to 0.
- Ordering: strict FIFO order per output. There is no ordering relation between A and B.
- `in_valid` low: no push, regardless of `in_sel`/`in_data`. An X on `in_sel` when `in_valid=0` must not corrupt state.
- Reset (any cycle, including mid-stream): both FIFOs empty, pointers 0, `a_valid=b_valid=0`, `a_data=b_data=0`, `a_count=b_count=0`. `in_ready` is 1 in the first cycle after reset. In-flight beats are discarded.

## Timing
- Latency: beat accepted at edge N is visible on `x_valid/x_data` during cycle N+1, i.e. poppable at edge N+1.
- Throughput: 1 beat/cycle sustained per output when the consumer holds `x_ready=1`. Aggregate input throughput is also 1 beat/cycle.
- FIFO occupancy per output ranges 0..DEPTH. Pointers are log2(DEPTH)+1 bits, and full/empty are derived from the MSB compare.
- `x_data` is held stable while `x_valid & !x_ready` (valid/ready stability rule). `x_valid` never drops without a pop or a reset.
- All outputs are registered or derived from registers, except `in_ready`, which is one 2:1 select of registered flags.

## Structure
- Shared package `lab_pkg`:
  - `SEL_A=1'b0`, `SEL_B=1'b1`.
  - the `clog2` helper constant function.
- Sub-module `lab_fifo` (params WIDTH, DEPTH; ports `clk, reset, push, push_data, pop, pop_data, full, empty`). It is instantiated twice.
- Top-level contains the push steering, `in_ready` select and the two counters.

## Test plan
- Reset, then alternate `in_sel` 0/1 with `in_data` 0x11, 0x22, 0x33, 0x44 and both readies high. Expect `a_data` 0x11 then 0x33, `b_data` 0x22 then 0x44, each one cycle after acceptance, and `a_count=b_count=2`.
- `a_ready=0`, push 0xA0, 0xA1 to A (DEPTH=2), then a third A beat. Expect `in_ready=0` for the third beat. In the same stall cycle, a B beat 0xB0 is accepted and appears on B.
- Full A FIFO with `a_ready=1` and a new A beat. Expect `in_ready=0` that cycle (no pass-through) and 1 the next cycle.
- Push 0x55 into empty A with `a_ready=1` in the same cycle. Expect `a_valid=0` that cycle, then `a_valid=1, a_data=0x55`.
- Deliver 256 beats to B with CNT_W=8. Expect `b_count` to wrap to 0.
- Assert `reset` with both FIFOs half full. Next cycle expect both valids 0, both counts 0, data 0 and `in_ready=1`.
